// File: rtl/log2_pipe_pkg.sv
// Shared constants for the log2 pipeline: default widths, stage count and the
// shift amounts of the quadratic mantissa correction.
package log2_pipe_pkg;
    localparam int W_DEF  = 16;
    localparam int F_DEF  = 8;
    localparam int TW_DEF = 4;
    localparam int STAGES = 3;
    // corr = (t >> CSH_A) + (t >> CSH_B) + (t >> CSH_C), roughly 0.34 * t
    localparam int CSH_A  = 2;
    localparam int CSH_B  = 4;
    localparam int CSH_C  = 5;
endpackage

// File: rtl/log2_lod.sv
// Leading-one detector: index of the most significant set bit plus a zero flag.
module log2_lod
    import log2_pipe_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic [W-1:0]         data,
    output logic [$clog2(W)-1:0] pos,
    output logic                 zero
);
    localparam int PW = $clog2(W);

    always_comb begin
        pos = '0;
        for (int i = 0; i < W; i++) begin
            if (data[i]) pos = PW'(i);
        end
    end

    assign zero = ~|data;
endmodule

// File: rtl/log2_pipe.sv
// Three-stage fixed-point log2: leading-one detect, normalise, correct/assemble.
// A single global stall keeps every stage and the valid shift register in lockstep.
module log2_pipe
    import log2_pipe_pkg::*;
#(
    parameter int W    = W_DEF,
    parameter int F    = F_DEF,
    parameter int CORR = 1,
    parameter int TW   = TW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    input  logic [TW-1:0] in_tag,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic          out_zero,
    output logic [TW-1:0] out_tag
);
    localparam int PW   = $clog2(W);
    localparam int KW   = W - F;
    localparam int KLIM = (KW >= 1) ? (1 << (KW - 1)) : 0;

    // Integer part k ranges from -F to W-1-F and must fit a KW-bit signed field.
    if (F < 1 || F >= W || F > KLIM || (W - 1 - F) > KLIM - 1) begin : g_bad_param
        $error("log2_pipe: illegal W/F combination");
    end

    logic [STAGES:1] vld_pipe;
    logic            adv;

    assign adv       = !vld_pipe[STAGES] || out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_pipe[STAGES];

    // S1: leading-one detect
    logic [PW-1:0] lod_p;
    logic          lod_z;
    logic [W-1:0]  s1_data;
    logic [PW-1:0] s1_p;
    logic          s1_z;
    logic [TW-1:0] s1_tag;

    log2_lod #(.W(W)) u_lod (
        .data (in_data),
        .pos  (lod_p),
        .zero (lod_z)
    );

    // S2: normalise so the leading one sits at bit W-1; fraction is the next F bits
    logic [PW-1:0]        shamt;
    logic [W-1:0]         aligned;
    logic [F-1:0]         f_n;
    logic signed [KW-1:0] k_n;
    logic [F-1:0]         s2_f;
    logic signed [KW-1:0] s2_k;
    logic                 s2_z;
    logic [TW-1:0]        s2_tag;

    always_comb begin
        shamt   = PW'(W - 1) - s1_p;
        aligned = s1_data << shamt;
        f_n     = F'(aligned >> (W - 1 - F));
        k_n     = KW'(int'(s1_p) - F);
    end

    // S3: f*(1-f) correction; f + corr stays below 2^F, so k and fc simply concatenate
    logic [F:0]   comp;
    logic [2*F:0] prod;
    logic [F-1:0] t;
    logic [F-1:0] corr;
    logic [F-1:0] fc;
    logic [W-1:0] res;

    always_comb begin
        comp = {1'b1, {F{1'b0}}} - {1'b0, s2_f};
        prod = {{(F + 1){1'b0}}, s2_f} * {{F{1'b0}}, comp};
        t    = F'(prod >> F);
        corr = (t >> CSH_A) + (t >> CSH_B) + (t >> CSH_C);
        fc   = s2_f + ((CORR != 0) ? corr : '0);
        res  = s2_z ? {1'b1, {(W - 1){1'b0}}} : {s2_k, fc};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            s1_data  <= '0;
            s1_p     <= '0;
            s1_z     <= 1'b0;
            s1_tag   <= '0;
            s2_f     <= '0;
            s2_k     <= '0;
            s2_z     <= 1'b0;
            s2_tag   <= '0;
            out_data <= '0;
            out_zero <= 1'b0;
            out_tag  <= '0;
        end else if (adv) begin
            vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
            s1_data  <= in_data;
            s1_p     <= lod_p;
            s1_z     <= lod_z;
            s1_tag   <= in_tag;
            s2_f     <= f_n;
            s2_k     <= k_n;
            s2_z     <= s1_z;
            s2_tag   <= s1_tag;
            out_data <= res;
            out_zero <= s2_z;
            out_tag  <= s2_tag;
        end
    end
endmodule

// File: tb/tb_log2_pipe.sv
// Directed and random-stall checks of log2_pipe (W=16, F=8) with CORR=1 and CORR=0 instances.
module tb_log2_pipe;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_data;
    logic [3:0]  in_tag;
    logic        out_ready;
    logic        in_ready, out_valid, out_zero;
    logic [15:0] out_data;
    logic [3:0]  out_tag;
    logic        in_ready0, out_valid0, out_zero0;
    logic [15:0] out_data0;
    logic [3:0]  out_tag0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    log2_pipe #(.W(16), .F(8), .CORR(1), .TW(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_tag(in_tag), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_zero(out_zero), .out_tag(out_tag)
    );

    log2_pipe #(.W(16), .F(8), .CORR(0), .TW(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .in_data(in_data), .in_tag(in_tag), .out_valid(out_valid0),
        .out_ready(out_ready), .out_data(out_data0), .out_zero(out_zero0), .out_tag(out_tag0)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Independent reference: integer log by halving, fraction by scaling x/2^p.
    function automatic logic [15:0] ref_log2(input logic [15:0] x, input bit corr);
        int p, f, t, c;
        if (x == 16'h0) return 16'h8000;
        p = 0;
        for (int v = int'(x); v > 1; v = v / 2) p++;
        f = ((int'(x) << 8) >> p) & 255;
        c = 0;
        if (corr) begin
            t = (f * (256 - f)) >> 8;
            c = (t >> 2) + (t >> 4) + (t >> 5);
        end
        return 16'((p - 8) * 256 + f + c);
    endfunction

    // One isolated sample; checks the 3-cycle latency and both CORR variants.
    task automatic run_vec(input logic [15:0] d, input logic [3:0] tg,
                           input logic [15:0] e1, input logic [15:0] e0, input logic ez);
        @(negedge clk);
        in_valid = 1'b1; in_data = d; in_tag = tg;
        @(negedge clk);
        in_valid = 1'b0;
        chk("lat_c1_valid", out_valid, 0);
        @(negedge clk);
        chk("lat_c2_valid", out_valid, 0);
        @(negedge clk);
        chk("lat_c3_valid", out_valid, 1);
        chk("vec_data", out_data, e1);
        chk("vec_zero", out_zero, ez);
        chk("vec_tag", out_tag, tg);
        chk("vec0_valid", out_valid0, 1);
        chk("vec0_data", out_data0, e0);
        chk("vec0_zero", out_zero0, ez);
        chk("vec0_tag", out_tag0, tg);
    endtask

    logic [20:0] exp_q[$];
    logic [20:0] e;
    logic [15:0] cur_d;
    int          sent, rcvd, cyc;

    task automatic gen_rand(output logic [15:0] d);
        int r;
        r = $urandom_range(0, 7);
        if (r == 0)      d = 16'h0;
        else if (r == 1) d = 16'(1 << $urandom_range(0, 15));
        else             d = 16'($urandom_range(0, 65535));
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_tag = '0; out_ready = 1'b1;
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_zero", out_zero, 0);
        chk("rst_out_tag", out_tag, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);

        run_vec(16'h0100, 4'h1, 16'h0000, 16'h0000, 1'b0);
        run_vec(16'h0200, 4'h2, 16'h0100, 16'h0100, 1'b0);
        run_vec(16'h0080, 4'h3, 16'hFF00, 16'hFF00, 1'b0);
        run_vec(16'h0180, 4'h4, 16'h0096, 16'h0080, 1'b0);
        run_vec(16'hFFFF, 4'h5, 16'h07FF, 16'h07FF, 1'b0);
        run_vec(16'h0001, 4'h6, 16'hF800, 16'hF800, 1'b0);
        run_vec(16'h0000, 4'h7, 16'h8000, 16'h8000, 1'b1);
        run_vec(16'h0100, 4'h8, 16'h0000, 16'h0000, 1'b0);
        run_vec(16'h0300, 4'h9, 16'h0196, 16'h0180, 1'b0);

        // Back-to-back stream with random backpressure against a scoreboard.
        sent = 0; rcvd = 0; cyc = 0;
        gen_rand(cur_d);
        while ((sent < 64 || rcvd < 64) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            out_ready = 1'($urandom_range(0, 1));
            in_valid  = (sent < 64);
            in_data   = cur_d;
            in_tag    = 4'(sent);
            #1;
            chk("in_ready_rule", in_ready, !(out_valid && !out_ready));
            if (in_valid && in_ready) begin
                exp_q.push_back({(cur_d == 16'h0), in_tag, ref_log2(cur_d, 1'b1)});
                sent++;
                gen_rand(cur_d);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rnd_extra_output", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rnd_data", out_data, e[15:0]);
                    chk("rnd_tag", out_tag, e[19:16]);
                    chk("rnd_zero", out_zero, e[20]);
                end
                rcvd++;
            end
        end
        chk("rnd_received", rcvd, 64);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("rnd_drained", out_valid, 0);
        end

        // Reset with three samples in flight.
        @(negedge clk); in_valid = 1'b1; in_data = 16'h0200; in_tag = 4'hA;
        @(negedge clk); in_data = 16'h0400; in_tag = 4'hB;
        @(negedge clk); in_data = 16'h0800; in_tag = 4'hC;
        @(negedge clk);
        chk("flight_valid", out_valid, 1);
        rst_n = 1'b0; in_valid = 1'b0;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_data", out_data, 0);
        chk("midrst_tag", out_tag, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("post_rst_valid", out_valid, 0);
            chk("post_rst_ready", in_ready, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
